// File: rtl/cpu_reg_writeback.sv
// -----------------------------------------------------------------------------
// cpu_reg_writeback
//
// Write-back sequencer for the single write port of the CPU register file.
// Results from the load unit and the ALU are accepted through valid/ready
// handshakes and queued in a DEPTH-entry FIFO. One queued write per cycle is
// retired onto the registered write port (writeen/addrw/writeint).
//
// Optional feature macro: CPU_WB_BYPASS_EN
//   defined   -> combinational forwarding of pending values to addr1/addr2
//   undefined -> fwd outputs tied to zero, no comparators are built
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   flush                      discard all pending writes (synchronous)
//   ld_valid/addr/data/ready   load-unit producer (fixed priority)
//   alu_valid/addr/data/ready  ALU producer
//   writeen/addrw/writeint     registered register-file write port
//   addr1/addr2                register-file read addresses (bypass lookup)
//   fwd1_hit/data, fwd2_hit/data  forwarded pending values
//   count                      entries currently queued
// -----------------------------------------------------------------------------
module cpu_reg_writeback #(
    parameter int XLEN  = 32,
    parameter int AW    = 5,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic                         ld_valid,
    input  logic [AW-1:0]                ld_addr,
    input  logic [XLEN-1:0]              ld_data,
    output logic                         ld_ready,
    input  logic                         alu_valid,
    input  logic [AW-1:0]                alu_addr,
    input  logic [XLEN-1:0]              alu_data,
    output logic                         alu_ready,
    output logic                         writeen,
    output logic [AW-1:0]                addrw,
    output logic [XLEN-1:0]              writeint,
    input  logic [AW-1:0]                addr1,
    input  logic [AW-1:0]                addr2,
    output logic                         fwd1_hit,
    output logic [XLEN-1:0]              fwd1_data,
    output logic                         fwd2_hit,
    output logic [XLEN-1:0]              fwd2_data,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [AW-1:0]   r_mem_addr [DEPTH];
    logic [XLEN-1:0] r_mem_data [DEPTH];
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic            r_writeen;
    logic [AW-1:0]   r_addrw;
    logic [XLEN-1:0] r_writeint;

    logic            w_full;
    logic            w_ld_acc;
    logic            w_alu_acc;
    logic            w_push;
    logic            w_pop;
    logic [AW-1:0]   w_in_addr;
    logic [XLEN-1:0] w_in_data;

    // Ready ignores a same-cycle pop so it never depends on the drain path.
    assign w_full    = (r_count == CW'(DEPTH));
    assign ld_ready  = !w_full && !flush;
    assign alu_ready = !w_full && !flush && !ld_valid;

    assign w_ld_acc  = ld_valid && ld_ready;
    assign w_alu_acc = alu_valid && alu_ready;
    assign w_in_addr = w_ld_acc ? ld_addr : alu_addr;
    assign w_in_data = w_ld_acc ? ld_data : alu_data;

    // Writes to x0 complete the handshake but are dropped here.
    assign w_push = (w_ld_acc || w_alu_acc) && (w_in_addr != '0);
    assign w_pop  = (r_count != '0) && !flush;

    // Storage has no reset: only slots below count are ever observed.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_addr[r_wr_ptr] <= w_in_addr;
            r_mem_data[r_wr_ptr] <= w_in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_writeen  <= 1'b0;
            r_addrw    <= '0;
            r_writeint <= '0;
        end else if (flush) begin
            // Accepts are blocked while flushing, so no push can race this.
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_writeen <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr   <= r_rd_ptr + PW'(1);
                r_addrw    <= r_mem_addr[r_rd_ptr];
                r_writeint <= r_mem_data[r_rd_ptr];
            end
            r_writeen <= w_pop;
            r_count   <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    assign writeen  = r_writeen;
    assign addrw    = r_addrw;
    assign writeint = r_writeint;
    assign count    = r_count;

`ifdef CPU_WB_BYPASS_EN
    // One lookup per read port. Sources are scanned oldest to youngest
    // (output stage, then queue head..tail) so the youngest match wins.
    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
        logic [AW-1:0]   w_raddr;
        logic            w_hit;
        logic [XLEN-1:0] w_data;

        assign w_raddr = (gi == 0) ? addr1 : addr2;

        always_comb begin
            w_hit  = 1'b0;
            w_data = '0;
            if (w_raddr != '0) begin
                if (r_writeen && (r_addrw == w_raddr)) begin
                    w_hit  = 1'b1;
                    w_data = r_writeint;
                end
                for (int k = 0; k < DEPTH; k++) begin
                    if ((CW'(k) < r_count) &&
                        (r_mem_addr[r_rd_ptr + PW'(k)] == w_raddr)) begin
                        w_hit  = 1'b1;
                        w_data = r_mem_data[r_rd_ptr + PW'(k)];
                    end
                end
            end
        end
    end

    assign fwd1_hit  = g_fwd[0].w_hit;
    assign fwd1_data = g_fwd[0].w_data;
    assign fwd2_hit  = g_fwd[1].w_hit;
    assign fwd2_data = g_fwd[1].w_data;
`else
    logic w_unused_addr;
    assign w_unused_addr = ^{addr1, addr2};

    assign fwd1_hit  = 1'b0;
    assign fwd1_data = '0;
    assign fwd2_hit  = 1'b0;
    assign fwd2_data = '0;
`endif

endmodule

// File: tb/tb_cpu_reg_writeback.sv
// -----------------------------------------------------------------------------
// tb_cpu_reg_writeback
//
// Self-checking bench for cpu_reg_writeback. A queue-based reference model
// tracks pending writes and the expected write-port contents; directed
// scenarios are followed by a randomized run. Honors CPU_WB_BYPASS_EN.
// -----------------------------------------------------------------------------
module tb_cpu_reg_writeback;

    localparam int XLEN  = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            flush;
    logic            ld_valid;
    logic [AW-1:0]   ld_addr;
    logic [XLEN-1:0] ld_data;
    logic            ld_ready;
    logic            alu_valid;
    logic [AW-1:0]   alu_addr;
    logic [XLEN-1:0] alu_data;
    logic            alu_ready;
    logic            writeen;
    logic [AW-1:0]   addrw;
    logic [XLEN-1:0] writeint;
    logic [AW-1:0]   addr1;
    logic [AW-1:0]   addr2;
    logic            fwd1_hit;
    logic [XLEN-1:0] fwd1_data;
    logic            fwd2_hit;
    logic [XLEN-1:0] fwd2_data;
    logic [2:0]      count;

    cpu_reg_writeback #(.XLEN(XLEN), .AW(AW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data), .ld_ready(ld_ready),
        .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data), .alu_ready(alu_ready),
        .writeen(writeen), .addrw(addrw), .writeint(writeint),
        .addr1(addr1), .addr2(addr2),
        .fwd1_hit(fwd1_hit), .fwd1_data(fwd1_data),
        .fwd2_hit(fwd2_hit), .fwd2_data(fwd2_data),
        .count(count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int n_txn    = 0;

    // Reference model: pending writes in acceptance order plus write port.
    typedef struct packed {
        logic [AW-1:0]   a;
        logic [XLEN-1:0] d;
    } ent_t;

    ent_t            q[$];
    logic            exp_we;
    logic [AW-1:0]   exp_addrw;
    logic [XLEN-1:0] exp_wd;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        exp_we    = 1'b0;
        exp_addrw = '0;
        exp_wd    = '0;
    endtask

    // Youngest pending value for a register, if any.
    task automatic ref_fwd(input logic [AW-1:0] a, output logic hit, output logic [XLEN-1:0] d);
        hit = 1'b0;
        d   = '0;
`ifdef CPU_WB_BYPASS_EN
        if (a != 0) begin
            if (exp_we && exp_addrw == a) begin
                hit = 1'b1;
                d   = exp_wd;
            end
            foreach (q[i]) begin
                if (q[i].a == a) begin
                    hit = 1'b1;
                    d   = q[i].d;
                end
            end
        end
`endif
    endtask

    // Apply one clock edge to the model using the currently driven inputs.
    task automatic model_edge();
        logic full;
        logic la;
        logic aa;
        ent_t e;
        full = (q.size() == DEPTH);
        if (flush) begin
            q.delete();
            exp_we = 1'b0;
        end else begin
            la = ld_valid && !full;
            aa = alu_valid && !full && !ld_valid;
            if (q.size() > 0) begin
                e         = q.pop_front();
                exp_we    = 1'b1;
                exp_addrw = e.a;
                exp_wd    = e.d;
            end else begin
                exp_we = 1'b0;
            end
            if (la && ld_addr != 0)
                q.push_back({ld_addr, ld_data});
            else if (aa && alu_addr != 0)
                q.push_back({alu_addr, alu_data});
        end
    endtask

    task automatic check_outputs();
        logic            h;
        logic [XLEN-1:0] d;
        logic            full;
        full = (q.size() == DEPTH);
        check("count",     64'(count),     64'(q.size()));
        check("writeen",   64'(writeen),   64'(exp_we));
        check("addrw",     64'(addrw),     64'(exp_addrw));
        check("writeint",  64'(writeint),  64'(exp_wd));
        check("ld_ready",  64'(ld_ready),  64'(!full && !flush));
        check("alu_ready", 64'(alu_ready), 64'(!full && !flush && !ld_valid));
        ref_fwd(addr1, h, d);
        check("fwd1_hit", 64'(fwd1_hit), 64'(h));
        if (h) check("fwd1_data", 64'(fwd1_data), 64'(d));
        ref_fwd(addr2, h, d);
        check("fwd2_hit", 64'(fwd2_hit), 64'(h));
        if (h) check("fwd2_data", 64'(fwd2_data), 64'(d));
    endtask

    // One transaction: drive inputs after the falling edge, check, clock, model.
    task automatic step(input logic lv, input logic [AW-1:0] la, input logic [XLEN-1:0] ldd,
                        input logic av, input logic [AW-1:0] aa, input logic [XLEN-1:0] ad,
                        input logic fl, input logic [AW-1:0] a1, input logic [AW-1:0] a2);
        ld_valid  = lv;  ld_addr  = la; ld_data  = ldd;
        alu_valid = av;  alu_addr = aa; alu_data = ad;
        flush     = fl;  addr1    = a1; addr2    = a2;
        #1;
        check_outputs();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        n_txn++;
        $display("txn %0d: ld=%b r%0d alu=%b r%0d flush=%b -> count=%0d we=%b r%0d=%h",
                 n_txn, lv, la, av, aa, fl, count, writeen, addrw, writeint);
    endtask

    task automatic idle();
        step(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        ld_valid = 0; ld_addr = 0; ld_data = 0;
        alu_valid = 0; alu_addr = 0; alu_data = 0;
        flush = 0; addr1 = 0; addr2 = 0;
        model_reset();
        #1;
        check_outputs();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Single write: visible one edge after acceptance, for one cycle.
        step(1'b0, '0, '0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0, '0);
        idle();
        check("single_we",   64'(writeen),  64'd1);
        check("single_addr", 64'(addrw),    64'd5);
        check("single_data", 64'(writeint), 64'hDEADBEEF);
        idle();
        check("single_we_off", 64'(writeen), 64'd0);

        // Priority: load wins, ALU waits a cycle; retire order r3 then r4.
        ld_valid = 1; ld_addr = 5'd3; ld_data = 32'h11;
        alu_valid = 1; alu_addr = 5'd4; alu_data = 32'h22;
        #1;
        check("prio_ld_ready",  64'(ld_ready),  64'd1);
        check("prio_alu_ready", 64'(alu_ready), 64'd0);
        step(1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 32'h22, 1'b0, '0, '0);
        step(1'b0, '0, '0, 1'b1, 5'd4, 32'h22, 1'b0, '0, '0);
        check("prio_first",  64'(addrw), 64'd3);
        idle();
        check("prio_second", 64'(addrw), 64'd4);
        idle();

        // Back-to-back accepts over 10 writes: pointers wrap, ready holds.
        for (int i = 1; i <= 10; i++)
            step(1'b1, AW'(i), XLEN'(i * 32'h101), 1'b0, '0, '0, 1'b0, '0, '0);
        idle();
        idle();

        // x0 writes are consumed but never retired.
        step(1'b0, '0, '0, 1'b1, 5'd0, 32'h55, 1'b0, '0, '0);
        check("x0_count", 64'(count), 64'd0);
        idle();
        check("x0_we", 64'(writeen), 64'd0);

        // Flush with pending work; accepts resume the cycle after.
        step(1'b0, '0, '0, 1'b1, 5'd6, 32'h66, 1'b0, '0, '0);
        step(1'b0, '0, '0, 1'b1, 5'd8, 32'h88, 1'b0, '0, '0);
        step(1'b0, '0, '0, 1'b1, 5'd9, 32'h99, 1'b1, '0, '0);
        check("flush_count", 64'(count),   64'd0);
        check("flush_we",    64'(writeen), 64'd0);
        step(1'b0, '0, '0, 1'b1, 5'd9, 32'h99, 1'b0, '0, '0);
        check("flush_resume", 64'(count), 64'd1);
        idle();
        idle();

        // Bypass: two writes to r7, the younger value must be forwarded.
        step(1'b0, '0, '0, 1'b1, 5'd7, 32'hA, 1'b0, '0, '0);
        step(1'b0, '0, '0, 1'b1, 5'd7, 32'hB, 1'b0, '0, '0);
        ld_valid = 0; alu_valid = 0; addr1 = 5'd7; addr2 = 5'd0;
        #1;
`ifdef CPU_WB_BYPASS_EN
        check("byp_hit1",  64'(fwd1_hit),  64'd1);
        check("byp_data1", 64'(fwd1_data), 64'hB);
`else
        check("byp_hit1",  64'(fwd1_hit),  64'd0);
        check("byp_data1", 64'(fwd1_data), 64'd0);
`endif
        check("byp_hit2", 64'(fwd2_hit), 64'd0);
        idle();
        idle();

        // Asynchronous reset mid-operation.
        step(1'b0, '0, '0, 1'b1, 5'd2, 32'h12, 1'b0, '0, '0);
        step(1'b0, '0, '0, 1'b1, 5'd3, 32'h34, 1'b0, '0, '0);
        ld_valid = 0; alu_valid = 0; addr1 = 5'd3; addr2 = 5'd2;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("rst_we",    64'(writeen),  64'd0);
        check("rst_addrw", 64'(addrw),    64'd0);
        check("rst_data",  64'(writeint), 64'd0);
        check("rst_count", 64'(count),    64'd0);
        check("rst_fwd1",  64'(fwd1_hit), 64'd0);
        check("rst_fwd2",  64'(fwd2_hit), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle();
        check("rst_empty", 64'(count), 64'd0);

        // Randomized traffic with narrow addresses to provoke collisions.
        for (int i = 0; i < 300; i++)
            step(1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), $urandom,
                 1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), $urandom,
                 1'($urandom_range(0, 9) == 0),
                 AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)));
        idle();
        idle();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
